// File: rtl/cmp_pkg.sv
// Shared types and default widths for the shared compare unit.
package cmp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5
    } cmp_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/cmp_rr_arb.sv
// Two-way round-robin arbiter; priority goes to the requester not granted last.
module cmp_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
        end
    end

    // Reset to "last granted = 1" so requester 0 wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cmp_share_ctrl.sv
// One comparator shared by the branch unit and the ALU, with a single-entry
// result register, round-robin arbitration and saturating per-requester grant counts.
module cmp_share_ctrl
    import cmp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [5:0]            req_op_i,
    input  logic [2*DATA_W-1:0]   req_rs1_i,
    input  logic [2*DATA_W-1:0]   req_rs2_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic                  rsp_flag_o,
    output logic [DATA_W-1:0]     rsp_data_o,
    output logic [2*CNT_W-1:0]    gnt_cnt_o,
    input  logic                  cnt_clr_i
);

    // Signed less-than comes from the unsigned one: differing MSBs decide by sign alone.
    function automatic logic cmp_eval(input cmp_op_e op, input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        logic eq, ltu, lts;
        eq  = (a == b);
        ltu = (a < b);
        lts = (a[DATA_W-1] ^ b[DATA_W-1]) ? a[DATA_W-1] : ltu;
        case (op)
            CMP_EQ:  cmp_eval = eq;
            CMP_NE:  cmp_eval = !eq;
            CMP_LT:  cmp_eval = lts;
            CMP_GE:  cmp_eval = !lts;
            CMP_LTU: cmp_eval = ltu;
            CMP_GEU: cmp_eval = !ltu;
            default: cmp_eval = 1'b0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic              id_q, flag_q;
    logic [CNT_W-1:0]  cnt_q [2];
    logic [1:0]        gnt;
    logic              accept_en;
    logic              load;
    logic              sel;
    logic [DATA_W-1:0] op_a, op_b;
    cmp_op_e           op_sel;
    logic              flag_d;

    assign accept_en = rst_ni && ((state_q == ST_EMPTY) || rsp_ready_i);

    cmp_rr_arb u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .en_i   (accept_en),
        .gnt_o  (gnt)
    );

    assign req_ready_o = gnt;
    assign load        = |gnt;
    assign sel         = gnt[1];
    assign op_a        = sel ? req_rs1_i[2*DATA_W-1:DATA_W] : req_rs1_i[DATA_W-1:0];
    assign op_b        = sel ? req_rs2_i[2*DATA_W-1:DATA_W] : req_rs2_i[DATA_W-1:0];
    assign op_sel      = cmp_op_e'(sel ? req_op_i[5:3] : req_op_i[2:0]);
    assign flag_d      = cmp_eval(op_sel, op_a, op_b);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready_i && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            id_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                id_q   <= sel;
                flag_q <= flag_d;
            end
        end
    end

    // Clear wins over a same-cycle grant; counts stick at all-ones.
    for (genvar i = 0; i < 2; i++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q[i] <= '0;
            end else if (cnt_clr_i) begin
                cnt_q[i] <= '0;
            end else if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_id_o    = id_q;
    assign rsp_flag_o  = flag_q;
    assign rsp_data_o  = {{(DATA_W-1){1'b0}}, flag_q};
    assign gnt_cnt_o   = {cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Directed bench for cmp_share_ctrl (DATA_W=32, CNT_W=4).
module tb_cmp_share_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [5:0]      req_op;
    logic [2*DW-1:0] rs1;
    logic [2*DW-1:0] rs2;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic            rsp_flag;
    logic [DW-1:0]   rsp_data;
    logic [2*CW-1:0] gnt_cnt;
    logic            cnt_clr;

    int checks;
    int failures;

    cmp_share_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_rs1_i   (rs1),
        .req_rs2_i   (rs2),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_flag_o  (rsp_flag),
        .rsp_data_o  (rsp_data),
        .gnt_cnt_o   (gnt_cnt),
        .cnt_clr_i   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        if (idx == 0) begin
            req_op[2:0]  = op;
            rs1[DW-1:0]  = a;
            rs2[DW-1:0]  = b;
        end else begin
            req_op[5:3]     = op;
            rs1[2*DW-1:DW]  = a;
            rs2[2*DW-1:DW]  = b;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0; cnt_clr = 1'b0;
        req_op = '0; rs1 = '0; rs2 = '0;
        #12;
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL reset_rsp got v=%b id=%b d=%h exp 0", rsp_valid, rsp_id, rsp_data);
        end
        checks++;
        if (gnt_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", gnt_cnt); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lt_basic();
        set_req(0, 3'd2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 2'b01; rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL lt_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_flag !== 1'b1 || rsp_data !== 32'h1) begin
            failures++;
            $display("FAIL lt_rsp got v=%b id=%b f=%b d=%h exp v=1 id=0 f=1 d=00000001",
                     rsp_valid, rsp_id, rsp_flag, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lt_consume got v=%b exp=0", rsp_valid); end
    endtask

    task automatic test_ltu_basic();
        set_req(1, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 2'b10; rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL ltu_ready got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_flag !== 1'b0 || rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL ltu_rsp got v=%b id=%b f=%b d=%h exp v=1 id=1 f=0 d=00000000",
                     rsp_valid, rsp_id, rsp_flag, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_unused_op();
        set_req(0, 3'd6, 32'h5, 32'h5);
        req_valid = 2'b01; rsp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_flag !== 1'b0 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL op6 got v=%b id=%b f=%b exp v=1 id=0 f=0", rsp_valid, rsp_id, rsp_flag);
        end
        tick();
        // requester 0 was granted last; a single grant to 1 restores pointer = 1
        set_req(1, 3'd0, 32'h0, 32'h0);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (gnt_cnt !== 8'h00) begin failures++; $display("FAIL clr_cnt got=%h exp=00", gnt_cnt); end
        set_req(0, 3'd0, 32'h5, 32'h5);
        set_req(1, 3'd1, 32'h5, 32'h5);
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL contend_ready[%0d] got=%b exp=%b", k, req_ready,
                                     (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== (k % 2 == 1) || rsp_flag !== (k % 2 == 0)) begin
                failures++; $display("FAIL contend_rsp[%0d] got v=%b id=%b f=%b", k, rsp_valid, rsp_id, rsp_flag);
            end
        end
        req_valid = 2'b00;
        checks++;
        if (gnt_cnt !== 8'h22) begin failures++; $display("FAIL contend_cnt got=%h exp=22", gnt_cnt); end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL contend_drain got v=%b exp=0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        set_req(0, 3'd3, 32'h0000_0003, 32'hFFFF_FFFE);
        set_req(1, 3'd5, 32'h0000_0003, 32'hFFFF_FFFE);
        req_valid = 2'b01; rsp_ready = 1'b0;
        tick();
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready got=%b exp=00", req_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_flag !== 1'b1 || rsp_data !== 32'h1
                || req_ready !== 2'b00) begin
                failures++; $display("FAIL bp_hold[%0d] got v=%b id=%b f=%b d=%h rdy=%b", k,
                                     rsp_valid, rsp_id, rsp_flag, rsp_data, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_release_ready got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_flag !== 1'b0) begin
            failures++; $display("FAIL bp_next got v=%b id=%b f=%b exp v=1 id=1 f=0", rsp_valid, rsp_id, rsp_flag);
        end
        tick();
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_req(0, 3'd0, 32'h1, 32'h2);
        req_valid = 2'b01; rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (gnt_cnt !== 8'h0F) begin failures++; $display("FAIL sat_cnt got=%h exp=0f", gnt_cnt); end
        cnt_clr = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL sat_clr_ready got=%b exp=01", req_ready); end
        tick();
        cnt_clr = 1'b0;
        req_valid = 2'b00;
        checks++;
        if (gnt_cnt !== 8'h00) begin failures++; $display("FAIL sat_clr got=%h exp=00", gnt_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        set_req(0, 3'd0, 32'h7, 32'h7);
        set_req(1, 3'd0, 32'h7, 32'h7);
        req_valid = 2'b01; rsp_ready = 1'b0;
        tick();
        req_valid = 2'b11;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_flag !== 1'b1) begin
            failures++; $display("FAIL mid_full got v=%b f=%b exp v=1 f=1", rsp_valid, rsp_flag);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_flag !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 2'b00
            || gnt_cnt !== 8'h00) begin
            failures++; $display("FAIL mid_reset got v=%b f=%b d=%h rdy=%b cnt=%h",
                                 rsp_valid, rsp_flag, rsp_data, req_ready, gnt_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
            failures++; $display("FAIL mid_release got v=%b rdy=%b exp v=0 rdy=01", rsp_valid, req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL mid_first got v=%b id=%b exp v=1 id=0", rsp_valid, rsp_id);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_lt_basic();
        test_ltu_basic();
        test_unused_op();
        test_contention();
        test_backpressure();
        test_saturation();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
